dmem_ctrl: RTL
==============

// Module: dmem_ctrl
// PURPOSE
//  Data-memory controller directly downstream of the core's load/store stage. Consumes its
//  cs/wr/mask/addr/data_wr request and returns aligned 32-bit read data on data_rd.
//  Owns a byte-enabled synchronous SRAM (1-cycle read latency).
//  Stalls the single-cycle core for one cycle on every load; stores complete with no stall.
// PARAMETERS
//  DEPTH_WORDS  1024          number of 32-bit words in the array (power of two)
//  BASE_ADDR    32'h0000_0000 byte address of word 0; must be DEPTH_WORDS*4 aligned
//  localparam IDX_W = $clog2(DEPTH_WORDS)
// PORTS
//  clk      in   1   single clock, all state on rising edge
//  rst      in   1   synchronous, active-high reset
//  cs       in   1   chip select, active-low; 0 = memory request this cycle
//  wr       in   1   active-low write; 0 = store, 1 = load (valid only when cs=0)
//  mask     in   4   byte-lane enables for stores (bit i -> data_wr[8i+7:8i])
//  addr     in   32  byte address; word index = (addr-BASE_ADDR)[IDX_W+1:2]
//  data_wr  in   32  lane-aligned store data
//  data_rd  out  32  raw word read from array (lane extraction done upstream)
//  stall    out  1   freeze PC/regfile write this cycle
//  err      out  1   one-cycle pulse: request address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS)
// BEHAVIOUR
//  Reset: state=IDLE, stall=0, err=0, data_rd=0; array contents not cleared.
//  FSM states (dmem_pkg::dmem_state_e): IDLE, LD_RESP.
//  IDLE, cs=1: no access; stall=0, data_rd=0.
//  IDLE, cs=0, wr=0 (store): write lanes where mask=1 at this rising edge; stall=0; stay IDLE.
//    mask=0000 with a store: no write, no error.
//  IDLE, cs=0, wr=1 (load): issue SRAM read of indexed word; stall=1 combinationally;
//    next state LD_RESP.
//  LD_RESP: data_rd = SRAM output; stall=0 so the core commits at this edge; next state IDLE
//    regardless of inputs (request still presented is the same load, not re-issued).
//  Load latency: 2 cycles (issue + response); store latency: 1 cycle; throughput 1 load / 2 clk.
//  Out of range (cs=0): err=1 in the same cycle; store suppressed; load still takes
//    2 cycles with data_rd=0 in LD_RESP (err asserted in the issue cycle only).
//  Store then load to the same word in consecutive instructions returns the new data
//    (write lands at the edge before the read is issued); no forwarding needed.
//  rst while in LD_RESP: state->IDLE, stall=0, data_rd=0 next cycle; a store presented with
//    rst=1 is not written.
//  cs/wr/mask are ignored in LD_RESP.
// CONFIGURATION
//  DMEM_PERF_CNT_EN defined: adds outputs ld_cnt[31:0], st_cnt[31:0]. ld_cnt increments on each
//    load issue (IDLE->LD_RESP) and st_cnt on each in-range store with mask!=0. Both saturate at
//    32'hFFFF_FFFF and clear on rst.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  dmem_pkg: dmem_state_e enum, MASK_NONE/MASK_ALL constants, CS_ACTIVE/WR_STORE (=1'b0) constants.
//  Sub-module dmem_sram: DEPTH_WORDS x 32 array, 4 byte-write enables, registered read port,
//    no reset. dmem_ctrl holds the FSM, range check, err and optional counters.
// TESTING
//  1) rst=1 for 2 cycles -> stall=0, err=0, data_rd=0; no array write while cs=0/wr=0 held.
//  2) store addr=BASE+0x10 data=32'hDEADBEEF mask=1111, then load same addr -> stall=1 for one
//     cycle, then data_rd=32'hDEADBEEF with stall=0.
//  3) store 32'h000000AA mask=0001 then 32'h00BB0000 mask=0100 to BASE+0x20 over prior 0 ->
//     load returns 32'h00BB00AA.
//  4) load at BASE+4*DEPTH_WORDS -> err=1 in issue cycle, data_rd=0 in LD_RESP; a store there
//     leaves word 0 unchanged.
//  5) assert rst in LD_RESP -> next cycle IDLE, stall=0; following load behaves normally.
//  6) [DMEM_PERF_CNT_EN] 3 loads + 2 stores (one with mask=0000) -> ld_cnt=3, st_cnt=1;
//     preload at 32'hFFFF_FFFF, one more load -> stays saturated.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory controller
package dmem_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    LD_RESP = 1'b1
  } dmem_state_e;

  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_ALL  = 4'b1111;
  localparam logic       CS_ACTIVE = 1'b0;
  localparam logic       WR_STORE  = 1'b0;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// rtl/dmem_sram.sv - byte-enabled single-port SRAM, one-cycle registered read, no reset
module dmem_sram
  import dmem_pkg::*;
#(
  parameter  int DEPTH_WORDS = 1024,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic [3:0]       we,
  input  logic             re,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[idx];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - data-memory controller: load FSM, range check, err pulse
// Optional load/store counters enabled by DMEM_PERF_CNT_EN.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter  int          DEPTH_WORDS = 1024,
  parameter  logic [31:0] BASE_ADDR   = 32'h0000_0000,
  localparam int          IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        wr,
  input  logic [3:0]  mask,
  input  logic [31:0] addr,
  input  logic [31:0] data_wr,
  output logic [31:0] data_rd,
  output logic        stall,
  output logic        err
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0] ld_cnt,
  output logic [31:0] st_cnt
`endif
);

  dmem_state_e      state_q, state_d;
  logic             oor_q, oor_d;
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             req, ld_issue, st_req;
  logic [3:0]       we;
  logic [31:0]      sram_rdata;
  logic             unused_addr_bits;

  // BASE_ADDR is aligned to the array size, so range reduces to matching the upper bits.
  assign idx              = addr[IDX_W+1:2];
  assign in_range         = (addr[31:IDX_W+2] == BASE_ADDR[31:IDX_W+2]);
  assign unused_addr_bits = ^addr[1:0];

  assign req      = (state_q == IDLE) && (cs == CS_ACTIVE) && !rst;
  assign ld_issue = req && (wr != WR_STORE);
  assign st_req   = req && (wr == WR_STORE);
  assign we       = (st_req && in_range) ? mask : MASK_NONE;

  dmem_sram #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
    .clk   (clk),
    .we    (we),
    .re    (ld_issue),
    .idx   (idx),
    .wdata (data_wr),
    .rdata (sram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      oor_q   <= oor_d;
    end
  end

  always_comb begin
    state_d = state_q;
    oor_d   = oor_q;
    case (state_q)
      IDLE: begin
        if (ld_issue) begin
          state_d = LD_RESP;
          oor_d   = !in_range;
        end
      end
      LD_RESP: begin
        state_d = IDLE;
        oor_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall   = 1'b0;
    err     = 1'b0;
    data_rd = 32'h0;
    case (state_q)
      IDLE: begin
        stall = ld_issue;
        err   = req && !in_range;
      end
      LD_RESP: data_rd = oor_q ? 32'h0 : sram_rdata;
      default: ;
    endcase
  end

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] ld_cnt_q, ld_cnt_d;
  logic [31:0] st_cnt_q, st_cnt_d;

  always_comb begin
    ld_cnt_d = ld_cnt_q;
    st_cnt_d = st_cnt_q;
    if (ld_issue) ld_cnt_d = sat_inc(ld_cnt_q);
    if (st_req && in_range && (mask != MASK_NONE)) st_cnt_d = sat_inc(st_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt_q <= 32'h0;
      st_cnt_q <= 32'h0;
    end else begin
      ld_cnt_q <= ld_cnt_d;
      st_cnt_q <= st_cnt_d;
    end
  end

  assign ld_cnt = ld_cnt_q;
  assign st_cnt = st_cnt_q;
`endif

endmodule
